// File: rtl/rt_pkg.sv
// Shared ray-tracing types: fixed-point word, triangle/ray layouts, batch mode and FSM states.
package rt_pkg;

  localparam int unsigned FIP_W    = 32;
  localparam int unsigned FIP_FRAC = 16;

  typedef logic signed [FIP_W-1:0] fip;

  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MIN = 32'sh8000_0000;
  localparam fip FIP_MAX = 32'sh7fff_ffff;

  // Three vertices of xyz, and origin/direction of xyz.
  typedef fip [0:2][0:2] tri_t;
  typedef fip [0:1][0:2] ray_t;

  typedef enum logic {
    ModeClosest = 1'b0,
    ModeAny     = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/hit_select.sv
// Accept/compare logic for retiring intersection results, plus the result registers.
module hit_select
  import rt_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  mode_e            mode_i,
  input  logic             retire_i,
  input  logic             hit_i,
  input  logic [W-1:0]     t_i,
  input  logic [W-1:0]     t_min_i,
  input  logic [W-1:0]     t_max_i,
  input  logic [CNT_W-1:0] index_i,
  output logic             accept_o,
  output logic             hit_o,
  output logic [W-1:0]     t_o,
  output logic [CNT_W-1:0] index_o
);

  localparam logic [W-1:0] FipMax = {1'b0, {(W-1){1'b1}}};

  logic             hit_q, hit_d;
  logic [W-1:0]     t_q, t_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic             in_window, closer;

  // Accept decision: window test always, then strict-closer or first-hit depending on mode.
  always_comb begin
    in_window = hit_i && ($signed(t_i) >= $signed(t_min_i)) && ($signed(t_i) < $signed(t_max_i));
    closer    = $signed(t_i) < $signed(t_q);
    accept_o  = retire_i && in_window && ((mode_i == ModeAny) ? !hit_q : closer);
  end

  // Next-state of result registers: a new batch clears them, an accepted result overwrites them.
  always_comb begin
    hit_d   = hit_q;
    t_d     = t_q;
    index_d = index_q;
    if (clear_i) begin
      hit_d   = 1'b0;
      t_d     = FipMax;
      index_d = '0;
    end else if (accept_o) begin
      hit_d   = 1'b1;
      t_d     = t_i;
      index_d = index_i;
    end
  end

  // Result register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q   <= 1'b0;
      t_q     <= FipMax;
      index_q <= '0;
    end else begin
      hit_q   <= hit_d;
      t_q     <= t_d;
      index_q <= index_d;
    end
  end

  assign hit_o   = hit_q;
  assign t_o     = t_q;
  assign index_o = index_q;

endmodule

// File: rtl/tri_batch_scan.sv
// Batch controller: issues triangle reads for one ray, forwards data to the intersection core,
// and reduces the in-order results to a single closest or any hit.
module tri_batch_scan
  import rt_pkg::*;
#(
  parameter int unsigned W            = 32,
  parameter int unsigned FRA_BITS     = 16,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ivalid,
  input  logic             i_mode,
  input  logic [31:0]      baseaddr,
  input  logic [6*W-1:0]   i_ray,
  input  logic [CNT_W-1:0] i_tri_cnt,
  input  logic [W-1:0]     i_t_min,
  input  logic [W-1:0]     i_t_max,
  output logic             o_busy,
  output logic             o_hit,
  output logic [W-1:0]     o_t,
  output logic [CNT_W-1:0] o_tri_index,
  output logic             o_finish,
  output logic             rd_read,
  output logic [CNT_W-1:0] rd_index,
  output logic [31:0]      rd_base,
  input  logic             rd_ready,
  input  logic             rd_valid,
  input  logic [9*W-1:0]   rd_data,
  output logic             isect_en,
  output logic [9*W-1:0]   isect_tri,
  output logic [6*W-1:0]   isect_ray,
  input  logic             isect_valid,
  input  logic             isect_hit,
  input  logic [W-1:0]     isect_t
);

  // One extra bit so the counter can hold MAX_INFLIGHT itself.
  localparam int unsigned     IfW     = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [IfW-1:0]  MaxInfl = IfW'(MAX_INFLIGHT);

  if (((MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) || (FRA_BITS >= W)) begin : g_param_check
    $error("tri_batch_scan: MAX_INFLIGHT must be a power of two and FRA_BITS < W");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [31:0]      base_q, base_d;
  logic [6*W-1:0]   ray_q, ray_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     tmin_q, tmin_d;
  logic [W-1:0]     tmax_q, tmax_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [IfW-1:0]   inflight_q, inflight_d;

  logic start, issue, retire, accept;

  // Handshakes and combinational forwarding; forwarding runs in every state so inflight drains.
  always_comb begin
    start     = (state_q == StIdle) && ivalid;
    rd_read   = (state_q == StIssue) && (issued_q < cnt_q) && (inflight_q < MaxInfl);
    issue     = rd_read && rd_ready;
    retire    = isect_valid && (inflight_q != '0);
    rd_index  = issued_q;
    rd_base   = base_q;
    isect_en  = rd_valid;
    isect_tri = rd_data;
    isect_ray = ray_q;
    o_busy    = (state_q == StIssue) || (state_q == StDrain);
    o_finish  = (state_q == StDone);
  end

  // Next-state: counters, latched batch parameters and FSM transitions.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    ray_d     = ray_q;
    cnt_d     = cnt_q;
    tmin_d    = tmin_q;
    tmax_d    = tmax_q;
    issued_d  = issue  ? issued_q + CNT_W'(1)  : issued_q;
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + IfW'(1);
      2'b01:   inflight_d = inflight_q - IfW'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (ivalid) begin
          mode_d     = mode_e'(i_mode);
          base_d     = baseaddr;
          ray_d      = i_ray;
          cnt_d      = i_tri_cnt;
          tmin_d     = i_t_min;
          tmax_d     = i_t_max;
          issued_d   = '0;
          retired_d  = '0;
          inflight_d = '0;
          state_d    = (i_tri_cnt == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if ((issued_d == cnt_q) || ((mode_q == ModeAny) && accept)) state_d = StDrain;
      end
      StDrain: begin
        if (inflight_d == '0) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM, counter and latch state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_q     <= ModeClosest;
      base_q     <= '0;
      ray_q      <= '0;
      cnt_q      <= '0;
      tmin_q     <= '0;
      tmax_q     <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      ray_q      <= ray_d;
      cnt_q      <= cnt_d;
      tmin_q     <= tmin_d;
      tmax_q     <= tmax_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      inflight_q <= inflight_d;
    end
  end

  // In-order core: the retire count is the index of the result being retired.
  hit_select #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_hit_select (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start),
    .mode_i   (mode_q),
    .retire_i (retire),
    .hit_i    (isect_hit),
    .t_i      (isect_t),
    .t_min_i  (tmin_q),
    .t_max_i  (tmax_q),
    .index_i  (retired_q),
    .accept_o (accept),
    .hit_o    (o_hit),
    .t_o      (o_t),
    .index_o  (o_tri_index)
  );

endmodule
